// File: rtl/iter_shifter_pkg.sv
// shift_pkg: shared types for the iterative shifter.
//   shift_mode_e : shift modes as carried on in_mode
//   state_e      : sequencing states of iter_shifter
// Configuration macro ITER_SHIFTER_ROTATE_EN decides whether SH_ROL rotates
// (defined) or aliases SH_SLL (undefined); the encoding itself is fixed.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shifter_if.sv
// iter_shifter_if: request/result handshake bundle for iter_shifter.
//   in_valid/in_ready   request handshake (operand, shift amount, mode)
//   out_valid/out_ready result handshake (out_data)
//   busy                shifter is working on or holding a request
// master: request source / result consumer.  slave: the shifter.
interface iter_shifter_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               busy;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// shift_step: combinational single step of the iterative shifter.
//   data   in   WIDTH      working value
//   amt    in   AMT_W      positions to shift this step, 0..STEP
//   mode   in   2          shift mode (shift_mode_e)
//   fill   in   1          bit shifted in for SRA
//   result out  WIDTH      shifted value
// Macro ITER_SHIFTER_ROTATE_EN: when undefined, SH_ROL falls into the SLL
// branch and no rotate path exists.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  shift_mode_e      mode,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  // One candidate per amount 1..STEP; amt==0 passes data through.
  always_comb begin
    result = data;
    for (int k = 1; k <= STEP; k++) begin
      if (amt == AMT_W'(k)) begin
        case (mode)
          SH_SRL: result = data >> k;
          // Fill mask: top k bits set to the sign; k==WIDTH gives all-fill.
          SH_SRA: result = ({WIDTH{fill}} << (WIDTH - k)) | (data >> k);
`ifdef ITER_SHIFTER_ROTATE_EN
          SH_ROL: result = (data << k) | (data >> (WIDTH - k));
`endif
          default: result = data << k;
        endcase
      end
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter, up to STEP bit positions per clock.
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of iter_shifter_if (request/result handshakes, busy)
// Parameters: WIDTH (power of two, >= 4), STEP (power of two, <= WIDTH).
// Macro ITER_SHIFTER_ROTATE_EN enables rotate-left for mode 11; otherwise
// mode 11 behaves as SLL.
//
// state    | meaning
// ST_IDLE  | waiting for a request, in_ready high
// ST_SHIFT | shifting the working register, rem counts down to 0
// ST_DONE  | result on out_data, waiting for out_ready
module iter_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input logic         clk,
  input logic         rst_n,
  iter_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int AMT_W   = $clog2(STEP + 1);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   data_q, data_d;
  shift_mode_e        mode_q, mode_d;
  logic               sign_q, sign_d;
  logic [AMT_W-1:0]   step_amt;
  logic [WIDTH-1:0]   step_res;

  // s = min(STEP, rem); compare in int so STEP==WIDTH does not overflow SHAMT_W.
  always_comb begin
    if (int'(rem_q) < STEP) step_amt = AMT_W'(rem_q);
    else                    step_amt = AMT_W'(STEP);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (data_q),
    .amt    (step_amt),
    .mode   (mode_q),
    .fill   (sign_q),
    .result (step_res)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          data_d  = bus.in_data;
          mode_d  = shift_mode_e'(bus.in_mode);
          sign_d  = bus.in_data[WIDTH-1];
          rem_d   = bus.in_shamt;
          state_d = (bus.in_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = step_res;
        rem_d  = rem_q - SHAMT_W'(step_amt);
        if (rem_q == SHAMT_W'(step_amt)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      mode_q  <= SH_SLL;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.in_ready  = rst_n & (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_data  = data_q;

endmodule
